pipe_skid_buf: RTL

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

---
 rtl/pipe_skid_buf.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with fully registered in_ready/out_valid handshakes.
// Optional upstream stall counter enabled by defining PIPE_SKID_BUF_STALL_CNT_EN.
module pipe_skid_buf #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             in_fire, out_fire;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = main_q;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (in_fire) begin
               state_d = StBusy;
               main_d  = in_data;
            end
         end
         StBusy: begin
            if (in_fire && !out_fire) begin
               state_d = StFull;
               skid_d  = in_data;
            end else if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (out_fire) begin
               state_d = StEmpty;
            end
         end
         StFull: begin
            // in_ready is low here, so only the drain side can move
            if (out_fire) begin
               state_d = StBusy;
               main_d  = skid_q;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Handshake flags track the next state so they never see out_ready/in_valid combinationally
      in_ready_d  = (state_d != StFull);
      out_valid_d = (state_d != StEmpty);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StEmpty;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Payload registers carry no reset; their contents are qualified by state
   always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
   end

`ifdef PIPE_SKID_BUF_STALL_CNT_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic                 stall;

   assign stall = in_valid & ~in_ready_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule
